// File: rtl/fetch_pkg.sv
// Shared definitions for the fetch stage: IF->ID bus layout, branch bundle layout,
// and the redirect-source encoding.
package fetch_pkg;

    localparam int FS2DS_LEN    = 65;
    localparam int FS_PC_LSB    = 0;
    localparam int FS_INST_LSB  = 32;
    localparam int FS_ADEF_BIT  = 64;

    localparam int BR_ZIP_LEN   = 34;
    localparam int BR_STALL_BIT = 33;
    localparam int BR_TAKEN_BIT = 32;

    typedef enum logic [1:0] {
        RD_EX   = 2'd0,
        RD_ERTN = 2'd1,
        RD_BR   = 2'd2
    } redir_src_e;

    function automatic logic [FS2DS_LEN-1:0] pack_fs2ds(
        input logic        adef,
        input logic [31:0] inst,
        input logic [31:0] pc
    );
        logic [FS2DS_LEN-1:0] bus;
        bus                     = '0;
        bus[FS_ADEF_BIT]        = adef;
        bus[FS_INST_LSB +: 32]  = inst;
        bus[FS_PC_LSB +: 32]    = pc;
        return bus;
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO with flush and occupancy count; storage is not reset, only the
// pointers and count are.
module fetch_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2
) (
    input  logic                         clk,
    input  logic                         resetn,
    input  logic                         flush,
    input  logic                         push,
    input  logic [WIDTH-1:0]             wdata,
    input  logic                         pop,
    output logic [WIDTH-1:0]             rdata,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         full,
    output logic                         empty
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wptr;
    logic [PTR_W-1:0] rptr;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign empty   = (count == '0);
    assign full    = (count == CNT_W'(DEPTH));
    // A pop frees the slot the same cycle, so push into a full FIFO is allowed alongside it.
    assign do_pop  = pop & ~empty & ~flush;
    assign do_push = push & (~full | do_pop) & ~flush;
    assign rdata   = mem[rptr];

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else if (flush) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (do_push) wptr <= next_ptr(wptr);
            if (do_pop)  rptr <= next_ptr(rptr);
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wptr] <= wdata;
    end

endmodule

// File: rtl/fetch_unit_mo.sv
// Pre-IF/IF fetch stage: issues pipelined inst-SRAM reads, buffers returned
// instructions in an IBUF for ID, and discards stale responses after a redirect.
module fetch_unit_mo
    import fetch_pkg::*;
#(
    parameter int          MAX_OUTSTANDING = 2,
    parameter int          IBUF_DEPTH      = 4,
    parameter logic [31:0] RESET_PC        = 32'h1C000000
) (
    input  logic                  clk,
    input  logic                  resetn,
    output logic                  inst_sram_req,
    output logic                  inst_sram_wr,
    output logic [1:0]            inst_sram_size,
    output logic [3:0]            inst_sram_wstrb,
    output logic [31:0]           inst_sram_addr,
    output logic [31:0]           inst_sram_wdata,
    input  logic                  inst_sram_addr_ok,
    input  logic                  inst_sram_data_ok,
    input  logic [31:0]           inst_sram_rdata,
    input  logic                  ds_allowin,
    input  logic [BR_ZIP_LEN-1:0] br_zip,
    output logic                  fs2ds_valid,
    output logic [FS2DS_LEN-1:0]  fs2ds_bus,
    input  logic                  wb_ex,
    input  logic                  ertn_flush,
    input  logic [31:0]           ex_entry,
    input  logic [31:0]           ertn_entry
);

    localparam int OUT_W = $clog2(MAX_OUTSTANDING + 1);
    localparam int CNT_W = $clog2(IBUF_DEPTH + 1);
    localparam int TOT_W = ((OUT_W > CNT_W) ? OUT_W : CNT_W) + 1;

    logic                 br_stall;
    logic                 br_taken;
    logic [31:0]          br_target;
    logic                 redir;
    redir_src_e           redir_src;
    logic [31:0]          redir_target;

    logic [31:0]          pc_req;
    logic                 halted;
    logic [OUT_W-1:0]     discard_cnt;

    logic [OUT_W-1:0]     outstanding;
    logic                 pend_full;
    logic                 pend_empty;
    logic [31:0]          pend_pc;

    logic [CNT_W-1:0]     ibuf_count;
    logic                 ibuf_full;
    logic                 ibuf_empty;
    logic [TOT_W-1:0]     out_total;

    logic                 misaligned;
    logic                 req_fire;
    logic                 drop_resp;
    logic                 adef_push;
    logic                 ibuf_push;
    logic                 ibuf_pop;
    logic [FS2DS_LEN-1:0] ibuf_wdata;

    function automatic logic [31:0] pick_target(
        input redir_src_e  src,
        input logic [31:0] ex_pc,
        input logic [31:0] ertn_pc,
        input logic [31:0] br_pc
    );
        case (src)
            RD_EX:   return ex_pc;
            RD_ERTN: return ertn_pc;
            default: return br_pc;
        endcase
    endfunction

    assign br_stall  = br_zip[BR_STALL_BIT];
    assign br_taken  = br_zip[BR_TAKEN_BIT];
    assign br_target = br_zip[31:0];

    always_comb begin
        redir_src = RD_BR;
        if (wb_ex)           redir_src = RD_EX;
        else if (ertn_flush) redir_src = RD_ERTN;
    end

    assign redir        = wb_ex | ertn_flush | br_taken;
    assign redir_target = pick_target(redir_src, ex_entry, ertn_entry, br_target);

    // The redirect target goes out combinationally so no request ever uses a stale PC.
    assign inst_sram_addr  = redir ? redir_target : pc_req;
    assign inst_sram_wr    = 1'b0;
    assign inst_sram_size  = 2'b10;
    assign inst_sram_wstrb = 4'b0000;
    assign inst_sram_wdata = 32'h0;

    assign misaligned = (inst_sram_addr[1:0] != 2'b00);
    // Every in-flight request reserves an IBUF slot, so returned data always has room.
    assign out_total  = TOT_W'(outstanding) + TOT_W'(ibuf_count);

    assign inst_sram_req = resetn & ~halted & ~br_stall & ~misaligned & ~pend_full
                         & (out_total < TOT_W'(IBUF_DEPTH));
    assign req_fire      = inst_sram_req & inst_sram_addr_ok;

    assign drop_resp  = redir | (discard_cnt != '0);
    // ADEF waits for all older traffic to drain so the fault entry lands in program order.
    assign adef_push  = misaligned & ~halted & ~redir & pend_empty
                      & (discard_cnt == '0) & ~ibuf_full;
    assign ibuf_push  = adef_push | (inst_sram_data_ok & ~drop_resp);
    assign ibuf_wdata = adef_push ? pack_fs2ds(1'b1, 32'h0, pc_req)
                                  : pack_fs2ds(1'b0, inst_sram_rdata, pend_pc);

    assign fs2ds_valid = ~ibuf_empty;
    assign ibuf_pop    = fs2ds_valid & ds_allowin & ~redir;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            pc_req      <= RESET_PC;
            halted      <= 1'b0;
            discard_cnt <= '0;
        end else begin
            if (req_fire)   pc_req <= inst_sram_addr + 32'd4;
            else if (redir) pc_req <= redir_target;

            if (redir)          halted <= 1'b0;
            else if (adef_push) halted <= 1'b1;

            // Only requests accepted before the redirect are stale; one accepted now is kept.
            if (redir)
                discard_cnt <= outstanding - OUT_W'(inst_sram_data_ok);
            else if (inst_sram_data_ok && (discard_cnt != '0))
                discard_cnt <= discard_cnt - OUT_W'(1);
        end
    end

    fetch_fifo #(
        .WIDTH (32),
        .DEPTH (MAX_OUTSTANDING)
    ) u_pend_fifo (
        .clk    (clk),
        .resetn (resetn),
        .flush  (1'b0),
        .push   (req_fire),
        .wdata  (inst_sram_addr),
        .pop    (inst_sram_data_ok),
        .rdata  (pend_pc),
        .count  (outstanding),
        .full   (pend_full),
        .empty  (pend_empty)
    );

    fetch_fifo #(
        .WIDTH (FS2DS_LEN),
        .DEPTH (IBUF_DEPTH)
    ) u_ibuf (
        .clk    (clk),
        .resetn (resetn),
        .flush  (redir),
        .push   (ibuf_push),
        .wdata  (ibuf_wdata),
        .pop    (ibuf_pop),
        .rdata  (fs2ds_bus),
        .count  (ibuf_count),
        .full   (ibuf_full),
        .empty  (ibuf_empty)
    );

    no_orphan_resp: assert property (@(posedge clk) disable iff (!resetn)
        inst_sram_data_ok |-> !pend_empty);

endmodule

// File: tb/tb_fetch_unit_mo.sv
// Scoreboard bench for fetch_unit_mo: a randomized SRAM responder, an expected
// instruction-stream queue rebuilt on every redirect/reset, and a decoupled monitor.
module tb_fetch_unit_mo;

    localparam logic [31:0] RESET_PC = 32'h1C000000;

    logic        clk = 1'b0;
    logic        resetn;
    logic        inst_sram_req, inst_sram_wr;
    logic [1:0]  inst_sram_size;
    logic [3:0]  inst_sram_wstrb;
    logic [31:0] inst_sram_addr, inst_sram_wdata;
    logic        inst_sram_addr_ok = 1'b0;
    logic        inst_sram_data_ok = 1'b0;
    logic [31:0] inst_sram_rdata   = 32'h0;
    logic        ds_allowin;
    logic [33:0] br_zip;
    logic        fs2ds_valid;
    logic [64:0] fs2ds_bus;
    logic        wb_ex, ertn_flush;
    logic [31:0] ex_entry, ertn_entry;

    always #5 clk = ~clk;

    fetch_unit_mo #(
        .MAX_OUTSTANDING (2),
        .IBUF_DEPTH      (4),
        .RESET_PC        (RESET_PC)
    ) dut (
        .clk               (clk),
        .resetn            (resetn),
        .inst_sram_req     (inst_sram_req),
        .inst_sram_wr      (inst_sram_wr),
        .inst_sram_size    (inst_sram_size),
        .inst_sram_wstrb   (inst_sram_wstrb),
        .inst_sram_addr    (inst_sram_addr),
        .inst_sram_wdata   (inst_sram_wdata),
        .inst_sram_addr_ok (inst_sram_addr_ok),
        .inst_sram_data_ok (inst_sram_data_ok),
        .inst_sram_rdata   (inst_sram_rdata),
        .ds_allowin        (ds_allowin),
        .br_zip            (br_zip),
        .fs2ds_valid       (fs2ds_valid),
        .fs2ds_bus         (fs2ds_bus),
        .wb_ex             (wb_ex),
        .ertn_flush        (ertn_flush),
        .ex_entry          (ex_entry),
        .ertn_entry        (ertn_entry)
    );

    typedef struct { logic adef; logic [31:0] pc; } exp_t;
    typedef struct { logic [31:0] addr; int unsigned ready; } sram_t;

    exp_t        exp_q[$];
    sram_t       sram_q[$];
    logic        bad_stream = 1'b0;
    int          total = 0;
    int          bad   = 0;
    int unsigned cyc   = 0;
    bit          aok_rand  = 1'b0;
    bit          aok_force = 1'b1;
    int unsigned lat_min = 2;
    int unsigned lat_max = 2;

    function automatic logic [31:0] memf(input logic [31:0] a);
        return (a * 32'h9E3779B1) ^ 32'h5A5A0F0F;
    endfunction

    task automatic check(input string name, input logic [64:0] act, input logic [64:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic extend_stream();
        while (exp_q.size() > 0 && exp_q.size() < 8 && !exp_q[$].adef)
            exp_q.push_back('{adef: 1'b0, pc: exp_q[$].pc + 32'd4});
    endtask

    task automatic restart_stream(input logic [31:0] t);
        exp_q.delete();
        bad_stream = (t[1:0] != 2'b00);
        exp_q.push_back('{adef: bad_stream, pc: t});
        extend_stream();
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // SRAM model: in-order responses after a per-request latency.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            inst_sram_data_ok = 1'b0;
            if (!resetn) begin
                inst_sram_addr_ok = 1'b0;
            end else begin
                inst_sram_addr_ok = aok_rand ? ($urandom_range(3, 0) != 0) : aok_force;
                inst_sram_rdata   = $urandom;
                if (sram_q.size() > 0 && sram_q[0].ready <= cyc) begin
                    inst_sram_data_ok = 1'b1;
                    inst_sram_rdata   = memf(sram_q[0].addr);
                    void'(sram_q.pop_front());
                end
            end
        end
    end

    // Monitor: records accepted requests and scores every ID handshake.
    initial begin
        exp_t        e;
        logic [64:0] expbus;
        logic        redir_in;
        int          idle;
        int unsigned l;
        idle = 0;
        forever begin
            @(negedge clk);
            if (!resetn) begin
                idle = 0;
            end else begin
                redir_in = wb_ex | ertn_flush | br_zip[32];
                if (inst_sram_req && inst_sram_addr_ok) begin
                    l = lat_min + $urandom_range(lat_max - lat_min, 0);
                    sram_q.push_back('{addr: inst_sram_addr, ready: cyc + l});
                end
                if (br_zip[33]) check("req_low_in_br_stall", 65'(inst_sram_req), 65'd0);
                if (bad_stream && !redir_in) check("no_req_while_adef", 65'(inst_sram_req), 65'd0);
                if (fs2ds_valid && ds_allowin && !redir_in) begin
                    idle = 0;
                    if (exp_q.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL unexpected_output: actual pc=%h required no output", fs2ds_bus[31:0]);
                    end else begin
                        e = exp_q.pop_front();
                        expbus = {e.adef, (e.adef ? 32'h0 : memf(e.pc)), e.pc};
                        check("fs2ds_bus", fs2ds_bus, expbus);
                        extend_stream();
                    end
                end else if (ds_allowin && !bad_stream && !redir_in && !br_zip[33]) begin
                    idle++;
                    if (idle > 60) begin
                        total++;
                        bad++;
                        $display("FAIL watchdog: actual=no output for 60 cycles required=progress");
                        idle = 0;
                    end
                end
            end
        end
    end

    task automatic do_redirect(input logic ex, input logic ertn, input logic br,
                               input logic [31:0] t_ex, input logic [31:0] t_ertn,
                               input logic [31:0] t_br, input string name);
        logic [31:0] t;
        wb_ex      = ex;
        ertn_flush = ertn;
        ex_entry   = t_ex;
        ertn_entry = t_ertn;
        br_zip     = {1'b0, br, t_br};
        t = ex ? t_ex : (ertn ? t_ertn : t_br);
        restart_stream(t);
        #1 check(name, 65'(inst_sram_addr), 65'(t));
        tick();
        wb_ex      = 1'b0;
        ertn_flush = 1'b0;
        br_zip     = '0;
    endtask

    task automatic wait_out2(input string name);
        int k;
        k = 0;
        while (!(sram_q.size() == 2 && !inst_sram_data_ok) && k < 40) begin
            tick();
            k++;
        end
        if (k >= 40) begin
            total++;
            bad++;
            $display("FAIL %s: actual=timeout required=2 outstanding", name);
        end
    endtask

    initial begin
        int cnt;
        int k;
        resetn = 1'b0; ds_allowin = 1'b1; br_zip = '0;
        wb_ex = 1'b0; ertn_flush = 1'b0; ex_entry = '0; ertn_entry = '0;
        repeat (3) tick();
        check("rst_fs2ds_valid", 65'(fs2ds_valid), 65'd0);
        check("rst_req", 65'(inst_sram_req), 65'd0);
        check("rst_addr", 65'(inst_sram_addr), 65'(RESET_PC));
        check("const_wr", 65'(inst_sram_wr), 65'd0);
        check("const_size", 65'(inst_sram_size), 65'd2);
        check("const_wstrb", 65'(inst_sram_wstrb), 65'd0);
        check("const_wdata", 65'(inst_sram_wdata), 65'd0);

        // 1: streaming from RESET_PC with single-cycle response turnaround
        lat_min = 1; lat_max = 1;
        restart_stream(RESET_PC);
        resetn = 1'b1;
        #1 check("first_req", 65'(inst_sram_req), 65'd1);
        check("first_addr", 65'(inst_sram_addr), 65'(RESET_PC));
        repeat (4) tick();
        for (int i = 0; i < 8; i++) begin
            check("stream_no_gap", 65'(fs2ds_valid), 65'd1);
            tick();
        end

        // 2: ID backpressure fills the IBUF and throttles requests
        lat_min = 2; lat_max = 2;
        ds_allowin = 1'b0;
        repeat (10) tick();
        check("stall_valid", 65'(fs2ds_valid), 65'd1);
        check("stall_req_low", 65'(inst_sram_req), 65'd0);
        aok_force = 1'b0;
        ds_allowin = 1'b1;
        cnt = 0;
        for (int i = 0; i < 8; i++) begin
            if (fs2ds_valid) cnt++;
            tick();
        end
        check("ibuf_held_entries", 65'(cnt), 65'd4);
        aok_force = 1'b1;
        repeat (10) tick();

        // 3 and 4: redirects with requests in flight
        lat_min = 3; lat_max = 3;
        wait_out2("wait_br");
        do_redirect(1'b0, 1'b0, 1'b1, 32'h0, 32'h0, 32'h1C000100, "br_addr");
        repeat (15) tick();
        wait_out2("wait_ex");
        do_redirect(1'b1, 1'b0, 1'b1, 32'h1C000400, 32'h0, 32'h1C000500, "ex_over_br");
        repeat (15) tick();
        k = 0;
        while (!inst_sram_data_ok && k < 40) begin tick(); k++; end
        if (k >= 40) begin total++; bad++; $display("FAIL wait_data_ok: actual=timeout required=data_ok"); end
        do_redirect(1'b0, 1'b1, 1'b1, 32'h0, 32'h1C000600, 32'h1C000700, "ertn_over_br_dataok");
        repeat (15) tick();

        // 5: misaligned branch target halts fetch until the next redirect
        do_redirect(1'b0, 1'b0, 1'b1, 32'h0, 32'h0, 32'h1C000102, "adef_addr");
        repeat (15) tick();
        check("adef_delivered", 65'(exp_q.size()), 65'd0);
        do_redirect(1'b0, 1'b1, 1'b0, 32'h0, 32'h1C000200, 32'h0, "ertn_resume");
        repeat (15) tick();

        // 6: asynchronous reset in the middle of a burst
        lat_min = 2; lat_max = 2;
        ds_allowin = 1'b0;
        repeat (3) tick();
        resetn = 1'b0;
        #1 check("midrst_valid", 65'(fs2ds_valid), 65'd0);
        check("midrst_req", 65'(inst_sram_req), 65'd0);
        check("midrst_addr", 65'(inst_sram_addr), 65'(RESET_PC));
        sram_q.delete();
        restart_stream(RESET_PC);
        ds_allowin = 1'b1;
        tick();
        tick();
        resetn = 1'b1;
        #1 check("restart_addr", 65'(inst_sram_addr), 65'(RESET_PC));
        repeat (15) tick();

        // Randomized traffic, backpressure and redirects
        aok_rand = 1'b1;
        lat_min = 1; lat_max = 3;
        for (int i = 0; i < 2500; i++) begin
            int r;
            logic [31:0] ta;
            logic [31:0] tb;
            ds_allowin = ($urandom_range(3, 0) != 0);
            r  = bad_stream ? int'($urandom_range(9, 0)) : int'($urandom_range(63, 0));
            ta = 32'h1C000000 + ($urandom_range(1023, 0) << 2);
            tb = 32'h1C010000 + ($urandom_range(1023, 0) << 2);
            if (r == 0)
                do_redirect(1'b1, 1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)),
                            ta, tb, ta + 32'd8, "rnd_redir_ex");
            else if (r == 1)
                do_redirect(1'b0, 1'b1, 1'($urandom_range(1, 0)), 32'h0, ta, tb, "rnd_redir_ertn");
            else if (r == 2)
                do_redirect(1'b0, 1'b0, 1'b1, 32'h0, 32'h0,
                            ($urandom_range(5, 0) == 0) ? (ta | 32'h2) : ta, "rnd_redir_br");
            else if (r < 6) begin
                br_zip = {1'b1, 1'b0, ta};
                tick();
                br_zip = '0;
            end else begin
                tick();
            end
        end
        ds_allowin = 1'b1;
        repeat (20) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
